// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS fetch/decode pipeline boundary.
package mips_pipe_pkg;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcplus4;
   } fetch_bundle_t;

   typedef enum logic {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_t;

endpackage

// File: rtl/fetch_skid_slot.sv
// Single-entry holding register that catches a fetched instruction while decode is stalled.
module fetch_skid_slot
   import mips_pipe_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          unload,
   input  logic          clear,
   input  fetch_bundle_t din,
   output fetch_bundle_t dout,
   output logic          full
);

   skid_state_t   state;
   skid_state_t   state_next;
   fetch_bundle_t entry;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SKID_EMPTY;
      else        state <= state_next;
   end

   // Load wins over unload: a simultaneous unload+load replaces the entry and stays FULL.
   always_comb begin
      // NOTE: default first, so no path through this block infers a latch.
      state_next = state;
      if (clear)       state_next = SKID_EMPTY;
      else if (load)   state_next = SKID_FULL;
      else if (unload) state_next = SKID_EMPTY;
   end

   // NOTE: the payload needs no reset; it is only ever read while state says FULL.
   always_ff @(posedge clk) begin
      if (load && !clear) entry <= din;
   end

   assign dout = entry;
   assign full = (state == SKID_FULL);

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid slot, bubble counter and sticky overflow flag.
module if_id_skid_reg
   import mips_pipe_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      InstrF,
   input  logic [31:0]      PCF,
   input  logic             FetchValidF,
   input  logic             StallD,
   input  logic             FlushD,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic             SkidFullF,
   output logic             OverflowErr,
   output logic [CNT_W-1:0] BubbleCount
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   fetch_bundle_t incoming;
   fetch_bundle_t skid_entry;
   fetch_bundle_t next_bundle;
   logic          skid_full;
   logic          skid_load;
   logic          skid_unload;
   logic          skid_clear;
   logic          decode_load;
   logic          decode_kill;
   logic          ovf_set;

   always_comb begin
      incoming.instr   = InstrF;
      incoming.pc      = PCF;
      incoming.pcplus4 = PCF + 32'd4;
   end

   fetch_skid_slot u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (skid_load),
      .unload (skid_unload),
      .clear  (skid_clear),
      .din    (incoming),
      .dout   (skid_entry),
      .full   (skid_full)
   );

   // Priority FlushD > StallD > advance; the skid entry is always older than the incoming one.
   always_comb begin
      skid_clear  = FlushD;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      decode_load = 1'b0;
      decode_kill = 1'b0;
      ovf_set     = 1'b0;
      next_bundle = incoming;
      if (FlushD) begin
         decode_kill = 1'b1;
      end else if (StallD) begin
         skid_load = FetchValidF && !skid_full;
         ovf_set   = FetchValidF && skid_full;
      end else if (skid_full) begin
         skid_unload = 1'b1;
         skid_load   = FetchValidF;
         decode_load = 1'b1;
         next_bundle = skid_entry;
      end else if (FetchValidF) begin
         decode_load = 1'b1;
      end else begin
         decode_kill = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrD   <= NOP_INSTR;
         PCD      <= RESET_PC;
         PCPlus4D <= RESET_PC;
         ValidD   <= 1'b0;
      end else if (decode_load) begin
         InstrD   <= next_bundle.instr;
         PCD      <= next_bundle.pc;
         PCPlus4D <= next_bundle.pcplus4;
         ValidD   <= 1'b1;
      end else if (decode_kill) begin
         InstrD   <= NOP_INSTR;
         ValidD   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         BubbleCount <= '0;
         OverflowErr <= 1'b0;
      end else begin
         if (!ValidD && (BubbleCount != CNT_MAX)) BubbleCount <= BubbleCount + CNT_ONE;
         if (ovf_set) OverflowErr <= 1'b1;
      end
   end

   assign SkidFullF = skid_full;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: fetched bundles are queued on drive and popped as they reach decode.
module tb_if_id_skid_reg;
   import mips_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] InstrF = '0;
   logic [31:0] PCF = '0;
   logic        FetchValidF = 1'b0;
   logic        StallD = 1'b0;
   logic        FlushD = 1'b0;

   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD, SkidFullF, OverflowErr;
   logic [31:0] BubbleCount;

   logic [31:0] s_instr, s_pc, s_pc4;
   logic        s_valid, s_skid, s_ovf;
   logic [3:0]  s_bub;

   always #5 clk = ~clk;

   if_id_skid_reg dut (
      .clk(clk), .rst_n(rst_n), .InstrF(InstrF), .PCF(PCF), .FetchValidF(FetchValidF),
      .StallD(StallD), .FlushD(FlushD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .SkidFullF(SkidFullF), .OverflowErr(OverflowErr), .BubbleCount(BubbleCount)
   );

   if_id_skid_reg #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .InstrF(InstrF), .PCF(PCF), .FetchValidF(FetchValidF),
      .StallD(StallD), .FlushD(FlushD), .InstrD(s_instr), .PCD(s_pc), .PCPlus4D(s_pc4),
      .ValidD(s_valid), .SkidFullF(s_skid), .OverflowErr(s_ovf), .BubbleCount(s_bub)
   );

   int n_checks = 0;
   int n_errors = 0;

   fetch_bundle_t q[$];
   logic        exp_valid;
   logic [31:0] exp_instr, exp_pc, exp_pc4, exp_bub;
   logic [3:0]  exp_bub4;
   logic        exp_ovf;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'h8C1F_0000;
   endfunction

   task automatic model_reset();
      q.delete();
      exp_valid = 1'b0;
      exp_instr = NOP;
      exp_pc    = 32'h0;
      exp_pc4   = 32'h0;
      exp_bub   = 32'h0;
      exp_bub4  = 4'h0;
      exp_ovf   = 1'b0;
   endtask

   task automatic check_reset_state();
      check("rst_valid", {31'b0, ValidD}, 32'h0);
      check("rst_instr", InstrD, NOP);
      check("rst_pcd", PCD, 32'h0);
      check("rst_pc4", PCPlus4D, 32'h0);
      check("rst_skid", {31'b0, SkidFullF}, 32'h0);
      check("rst_ovf", {31'b0, OverflowErr}, 32'h0);
      check("rst_bub", BubbleCount, 32'h0);
      check("rst_bub4", {28'b0, s_bub}, 32'h0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check_reset_state();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: drive inputs, queue what the spec says must eventually reach decode, then compare.
   task automatic step(input logic fv, input logic [31:0] pc, input logic st, input logic fl);
      fetch_bundle_t b;
      logic advance;
      FetchValidF = fv;
      PCF         = pc;
      InstrF      = instr_of(pc);
      StallD      = st;
      FlushD      = fl;
      advance     = !st && !fl;
      if (!exp_valid) begin
         if (exp_bub != 32'hFFFF_FFFF) exp_bub = exp_bub + 32'd1;
         if (exp_bub4 != 4'hF) exp_bub4 = exp_bub4 + 4'd1;
      end
      if (fl) begin
         q.delete();
      end else if (fv) begin
         if (advance || q.size() == 0) q.push_back('{instr: instr_of(pc), pc: pc, pcplus4: pc + 32'd4});
         else exp_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
      if (fl) begin
         exp_valid = 1'b0;
         exp_instr = NOP;
      end else if (advance) begin
         if (q.size() > 0) begin
            b = q.pop_front();
            exp_valid = 1'b1;
            exp_instr = b.instr;
            exp_pc    = b.pc;
            exp_pc4   = b.pcplus4;
         end else begin
            exp_valid = 1'b0;
            exp_instr = NOP;
         end
      end
      check("valid", {31'b0, ValidD}, {31'b0, exp_valid});
      check("instr", InstrD, exp_instr);
      check("pcd", PCD, exp_pc);
      check("pcplus4", PCPlus4D, exp_pc4);
      check("skid_full", {31'b0, SkidFullF}, {31'b0, q.size() != 0});
      check("overflow", {31'b0, OverflowErr}, {31'b0, exp_ovf});
      check("bubbles", BubbleCount, exp_bub);
      check("bubbles_sat", {28'b0, s_bub}, {28'b0, exp_bub4});
   endtask

   initial begin
      model_reset();
      apply_reset();

      // Idle after reset: count 1,2,3
      repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);

      // Streaming
      step(1'b1, 32'h0040_0030, 1'b0, 1'b0);
      step(1'b1, 32'h0040_0034, 1'b0, 1'b0);
      step(1'b1, 32'h0040_0038, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Stall capture: skid full for exactly two stalled cycles
      step(1'b1, 32'h0040_0030, 1'b0, 1'b0);
      step(1'b1, 32'h0040_0034, 1'b1, 1'b0);
      step(1'b0, 32'h0040_0034, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h0040_0038, 1'b0, 1'b0);

      // Skid refilled while unloading, then overflow on a full skid
      step(1'b1, 32'h0040_0034, 1'b1, 1'b0);
      step(1'b1, 32'h0040_0038, 1'b0, 1'b0);
      step(1'b1, 32'h0040_003C, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h0040_0034, 1'b1, 1'b0);
      step(1'b1, 32'h0040_0038, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Flush beats stall and discards the same-cycle fetch
      step(1'b1, 32'h0040_0040, 1'b0, 1'b0);
      step(1'b1, 32'h0040_0044, 1'b1, 1'b0);
      step(1'b1, 32'h0040_0048, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // PC+4 wrap, then a long bubble run to saturate the 4-bit counter
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
      repeat (20) step(1'b0, 32'h0, 1'b0, 1'b0);

      // Reset mid-operation with skid full and overflow set
      step(1'b1, 32'h0000_0100, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0104, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0108, 1'b1, 1'b0);
      apply_reset();
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0200, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      check("queue_drained", q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline register directly downstream of the fetch-stage PC register.
- Captures the fetched instruction, its PC and PC+4 into the decode stage.
- Includes a one-entry skid slot, so an instruction already in flight from synchronous instruction memory is not lost when decode stalls.
- Reports bubble statistics and a sticky protocol-error flag to the hazard/debug logic.

Parameters:
- NOP_INSTR, 32'h00000000, instruction word driven into decode on bubble/flush (sll $0,$0,0).
- RESET_PC, 32'h00000000, reset value of PCD and PCPlus4D.
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InstrF  in  32  instruction word returned by instruction memory.
- PCF  in  32  PC associated with InstrF.
- FetchValidF  in  1  InstrF/PCF hold a real instruction this cycle.
- StallD  in  1  hazard unit: hold decode registers.
- FlushD  in  1  hazard unit: kill decode contents (branch/jump redirect).
- InstrD  out  32  decode-stage instruction.
- PCD  out  32  decode-stage PC.
- PCPlus4D  out  32  decode-stage PC+4.
- ValidD  out  1  decode stage holds a real instruction.
- SkidFullF  out  1  skid slot occupied; hazard unit must force StallF while high.
- OverflowErr  out  1  sticky: an instruction arrived while the skid was full and decode was stalled.
- BubbleCount  out  CNT_W  saturating count of cycles with ValidD=0.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - InstrD=NOP_INSTR, PCD=PCPlus4D=RESET_PC, ValidD=0.
  - Skid slot EMPTY, SkidFullF=0, OverflowErr=0, BubbleCount=0.
- Reset mid-operation discards both the decode contents and the skid contents.
- Latency: one cycle from FetchValidF/InstrF to InstrD/ValidD when there is no stall and the skid is empty.
- PC+4 is computed internally as PCF+32'd4, modulo 2^32; 32'hFFFFFFFC wraps to 0. The skid slot stores PC, PC+4 and instruction.
- Skid slot states: EMPTY, FULL. SkidFullF is the registered state bit, with no combinational path from inputs.
- Per-edge priority is FlushD > StallD > advance.
- FlushD=1 (StallD ignored):
  - ValidD<=0, InstrD<=NOP_INSTR; PCD/PCPlus4D hold.
  - Skid goes to EMPTY.
  - The same-cycle FetchValidF instruction is discarded.
- StallD=1, FlushD=0:
  - Decode registers hold.
  - EMPTY and FetchValidF=1: capture into skid, go to FULL.
  - FULL and FetchValidF=1: incoming instruction dropped, skid keeps the older entry, OverflowErr<=1.
  - FetchValidF=0: skid unchanged.
- Advance (StallD=0, FlushD=0):
  - FULL: decode<=skid entry, ValidD<=1. If FetchValidF=1, the incoming instruction is loaded into the skid (stays FULL); otherwise go to EMPTY.
  - EMPTY and FetchValidF=1: decode<=incoming, ValidD<=1.
  - EMPTY and FetchValidF=0: bubble, ValidD<=0, InstrD<=NOP_INSTR; PCD/PCPlus4D hold.
- Ordering is preserved at all times: the skid entry is always older than the incoming instruction.
- BubbleCount:
  - Increments at each rising edge where ValidD is 0 before that edge, including stalled bubble cycles.
  - Saturates at all-ones and does not wrap.
- OverflowErr is cleared only by reset.

Decomposition:
- Shared package mips_pipe_pkg:
  - NOP constant.
  - fetch_bundle_t typedef {instr[31:0], pc[31:0], pcplus4[31:0]}.
  - skid_state_t enum {SKID_EMPTY, SKID_FULL}.
- One sub-module, fetch_skid_slot: a single-entry holding register with load/unload/clear controls and a full flag.
- The top level does the priority muxing, PC+4 adder, bubble counter and error flag.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> ValidD=0, InstrD=0, PCD=0, SkidFullF=0, BubbleCount counts 1,2,3... from the first edge after release.
- Streaming: FetchValidF=1 with PCF 0x00400030, 0x00400034, 0x00400038, no stall -> one cycle later PCD follows the same sequence, PCPlus4D=0x00400034..., ValidD=1, BubbleCount frozen.
- Stall capture: at PCD=0x00400030, StallD=1 for 2 cycles while FetchValidF=1 with 0x00400034 -> SkidFullF=1 for exactly those 2 cycles. After StallD drops, PCD=0x00400034 then the next fetched PC, with no loss or duplication.
- Overflow: skid FULL, StallD=1, a second FetchValidF=1 (0x00400038) -> OverflowErr=1 and sticky; skid still presents 0x00400034 on release.
- Flush priority: skid FULL, FlushD=1 and StallD=1 together -> next edge ValidD=0, InstrD=0, SkidFullF=0, same-cycle fetch discarded.
- Wrap/saturation: PCF=0xFFFFFFFC -> PCPlus4D=0x00000000. Force BubbleCount near all-ones (CNT_W=4 build) and hold bubbles -> it reaches 4'hF and stays there.
